// File: rtl/uart_dbg_master_if.sv
// Peripheral register bus between uart_dbg_master and the register space.
//   waddr_o/data_o/sel_o/we_o : single write, we_o a one-cycle strobe
//   raddr_o/rd_o              : single read, rd_o a one-cycle strobe
//   data_i                    : read data, valid the cycle after rd_o
interface uart_dbg_master_if;
  logic [7:0]  waddr_o;
  logic [31:0] data_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic [7:0]  raddr_o;
  logic        rd_o;
  logic [31:0] data_i;

  modport master (output waddr_o, data_o, sel_o, we_o, raddr_o, rd_o,
                  input  data_i);
  modport slave  (input  waddr_o, data_o, sel_o, we_o, raddr_o, rd_o,
                  output data_i);
endinterface

// File: rtl/uart_dbg_master.sv
// UART-driven debug initiator for the peripheral register bus.
// Receives 'W' addr sel d0..d3 / 'R' addr frames on rx_pin, issues one bus
// write or read, answers with ACK (0x06), 4 read-data bytes, or NAK (0x15).
//   clk, rst  : system clock, synchronous active-high reset
//   rx_pin    : async serial in (idle high); tx_pin : serial out (idle high)
//   bus       : register bus master port (see uart_dbg_master_if)
//   busy_o    : command FSM away from S_CMD or transmitter active
//   err_o     : one-cycle pulse on framing error, bad command, timeout
module uart_dbg_master #(
  parameter logic [15:0] BAUD_DIV    = 16'd434,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_pin,
  output logic              tx_pin,
  uart_dbg_master_if.master bus,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [15:0] BAUD_M1 = BAUD_DIV - 16'd1;
  localparam logic [15:0] HALF_M1 = (BAUD_DIV >> 1) - 16'd1;
  localparam logic [31:0] TO_M1   = TIMEOUT_CYC - 32'd1;
  localparam logic [7:0]  CMD_W   = 8'h57;
  localparam logic [7:0]  CMD_R   = 8'h52;
  localparam logic [7:0]  ACK     = 8'h06;
  localparam logic [7:0]  NAK     = 8'h15;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_e;
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_SEL, S_DATA,
                            S_WR, S_RD, S_CAP, S_RESP} st_e;

  // ---------------- RX ----------------
  logic        rx_s1_q, rx_s2_q;
  rx_st_e      rx_st_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rx_vld_q, rx_ferr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= R_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx_pin;
      rx_s2_q   <= rx_s1_q;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_st_q)
        // Only armed while the line was high, so a low level here is a fall.
        R_IDLE: if (!rx_s2_q) begin
          rx_st_q  <= R_START;
          rx_cnt_q <= '0;
        end
        R_START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? R_IDLE : R_DATA;  // high again: glitch
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        end
        R_DATA: begin
          if (rx_cnt_q == BAUD_M1) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        end
        R_STOP: begin
          if (rx_cnt_q == BAUD_M1) begin
            rx_cnt_q <= '0;
            if (rx_s2_q) begin
              rx_vld_q <= 1'b1;
              rx_st_q  <= R_IDLE;
            end else begin
              rx_ferr_q <= 1'b1;
              rx_st_q   <= R_WAIT;
            end
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        end
        R_WAIT:  if (rx_s2_q) rx_st_q <= R_IDLE;
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- TX ----------------
  logic        tx_q, tx_busy_q;
  logic [8:0]  tx_sh_q;   // remaining data bits + stop bit
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;  // 0 = start, 1..8 = data, 9 = stop
  logic        tx_end, tx_rdy, tx_ld_d;
  logic [7:0]  tx_byte_d;

  // A new byte may load in the last cycle of the stop bit: no idle gap.
  assign tx_end = tx_busy_q && (tx_cnt_q == BAUD_M1) && (tx_bit_q == 4'd9);
  assign tx_rdy = !tx_busy_q || tx_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
    end else if (tx_ld_d) begin
      tx_q      <= 1'b0;
      tx_sh_q   <= {1'b1, tx_byte_d};
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_busy_q <= 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BAUD_M1) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_q      <= 1'b1;
        end else begin
          tx_q     <= tx_sh_q[0];
          tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end else tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  // ---------------- command FSM ----------------
  st_e         st_q;
  logic        is_wr_q, we_q, rd_q, err_q;
  logic [7:0]  waddr_q, raddr_q;
  logic [3:0]  sel_q;
  logic [31:0] data_q;
  logic [23:0] resp_q;      // read bytes still to send, LSB next
  logic [1:0]  resp_cnt_q;
  logic [1:0]  bcnt_q;
  logic [31:0] to_q;

  // The first reply byte is launched straight from the decoding state so
  // tx_pin falls in the following cycle; the TX is always idle there.
  always_comb begin
    tx_ld_d   = 1'b0;
    tx_byte_d = 8'h00;
    case (st_q)
      S_CMD: if (rx_vld_q && rx_sh_q != CMD_W && rx_sh_q != CMD_R) begin
        tx_ld_d   = 1'b1;
        tx_byte_d = NAK;
      end
      S_WR: begin
        tx_ld_d   = 1'b1;
        tx_byte_d = ACK;
      end
      S_CAP: begin
        tx_ld_d   = 1'b1;
        tx_byte_d = bus.data_i[7:0];
      end
      S_RESP: if (resp_cnt_q != 2'd0 && tx_rdy) begin
        tx_ld_d   = 1'b1;
        tx_byte_d = resp_q[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= S_CMD;
      is_wr_q    <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      bcnt_q     <= '0;
      to_q       <= '0;
    end else begin
      we_q  <= 1'b0;
      rd_q  <= 1'b0;
      err_q <= rx_ferr_q;
      case (st_q)
        S_CMD: begin
          to_q   <= '0;
          bcnt_q <= '0;
          if (rx_vld_q) begin
            if (rx_sh_q == CMD_W) begin
              is_wr_q <= 1'b1;
              st_q    <= S_ADDR;
            end else if (rx_sh_q == CMD_R) begin
              is_wr_q <= 1'b0;
              st_q    <= S_ADDR;
            end else begin
              err_q      <= 1'b1;
              resp_cnt_q <= '0;
              st_q       <= S_RESP;
            end
          end
        end
        S_ADDR, S_SEL, S_DATA: begin
          // rx_valid beats a coinciding timeout expiry.
          if (rx_ferr_q) st_q <= S_CMD;
          else if (rx_vld_q) begin
            to_q <= '0;
            if (st_q == S_ADDR) begin
              if (is_wr_q) begin
                waddr_q <= rx_sh_q;
                st_q    <= S_SEL;
              end else begin
                raddr_q <= rx_sh_q;
                rd_q    <= 1'b1;   // high during S_RD
                st_q    <= S_RD;
              end
            end else if (st_q == S_SEL) begin
              sel_q <= rx_sh_q[3:0];
              st_q  <= S_DATA;
            end else begin
              data_q <= {rx_sh_q, data_q[31:8]};
              bcnt_q <= bcnt_q + 2'd1;
              if (bcnt_q == 2'd3) begin
                we_q <= 1'b1;      // high during S_WR
                st_q <= S_WR;
              end
            end
          end else if (to_q == TO_M1) begin
            err_q <= 1'b1;
            st_q  <= S_CMD;
          end else to_q <= to_q + 32'd1;
        end
        S_WR: begin
          resp_cnt_q <= '0;
          st_q       <= S_RESP;
        end
        S_RD: st_q <= S_CAP;
        S_CAP: begin
          resp_q     <= bus.data_i[31:8];
          resp_cnt_q <= 2'd3;
          st_q       <= S_RESP;
        end
        S_RESP: begin
          if (tx_ld_d) begin
            resp_q     <= {8'h00, resp_q[23:8]};
            resp_cnt_q <= resp_cnt_q - 2'd1;
          end else if (resp_cnt_q == 2'd0 && !tx_busy_q) st_q <= S_CMD;
        end
        default: st_q <= S_CMD;
      endcase
    end
  end

  assign tx_pin      = tx_q;
  assign busy_o      = (st_q != S_CMD) || tx_busy_q;
  assign err_o       = err_q;
  assign bus.waddr_o = waddr_q;
  assign bus.raddr_o = raddr_q;
  assign bus.sel_o   = sel_q;
  assign bus.data_o  = data_q;
  assign bus.we_o    = we_q;
  assign bus.rd_o    = rd_q;

endmodule

// File: tb/tb_uart_dbg_master.sv
// Directed bench for uart_dbg_master at BAUD_DIV=16, TIMEOUT_CYC=500.
module tb_uart_dbg_master;
  localparam int BD = 16;

  logic clk = 1'b0, rst = 1'b1, rx_pin = 1'b1;
  logic tx_pin, busy_o, err_o;
  int   checks = 0, errors = 0;

  uart_dbg_master_if bif();

  uart_dbg_master #(.BAUD_DIV(16'd16), .TIMEOUT_CYC(32'd500)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .tx_pin(tx_pin),
    .bus(bif), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Register model: read data appears the cycle after rd_o, zero otherwise.
  always @(posedge clk) bif.data_i <= bif.rd_o ? 32'hCAFEF00D : 32'h0;

  // Bus / err observers (monotonic counters, sampled on falling edge).
  int          we_n = 0, rd_n = 0, err_n = 0, err_long = 0;
  logic        err_prev = 1'b0;
  logic [7:0]  w_addr, r_addr;
  logic [3:0]  w_sel;
  logic [31:0] w_data;
  always @(negedge clk) begin
    if (bif.we_o) begin
      we_n++; w_addr = bif.waddr_o; w_sel = bif.sel_o; w_data = bif.data_o;
    end
    if (bif.rd_o) begin rd_n++; r_addr = bif.raddr_o; end
    if (err_o) err_n++;
    if (err_o && err_prev) err_long++;
    err_prev = err_o;
  end

  // Serial decoder for tx_pin.
  logic [7:0] tx_log [0:1023];
  int         tx_n = 0, stop_bad = 0;
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (!rst && tx_pin === 1'b0) begin
      repeat (BD/2) @(negedge clk);
      if (tx_pin === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx_pin;
        end
        repeat (BD) @(negedge clk);
        if (tx_pin !== 1'b1) stop_bad++;
        tx_log[tx_n] = b;
        tx_n++;
      end
    end
  end

  initial begin
    #800us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_pin = 1'b0; repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i]; repeat (BD) @(negedge clk);
    end
    rx_pin = stop; repeat (BD) @(negedge clk);
    rx_pin = 1'b1; repeat (2) @(negedge clk);
  endtask

  task automatic send_write(input logic [7:0] a, input logic [7:0] s, input logic [31:0] d);
    send_byte(8'h57, 1'b1); send_byte(a, 1'b1); send_byte(s, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic wait_tx(input string tag, input int target);
    int k = 0;
    while (tx_n < target && k < 3000) begin @(negedge clk); k++; end
    chk(tag, tx_n, target);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx"},    32'(tx_pin),        32'd1);
    chk({tag, "_we"},    32'(bif.we_o),      32'd0);
    chk({tag, "_rd"},    32'(bif.rd_o),      32'd0);
    chk({tag, "_waddr"}, 32'(bif.waddr_o),   32'd0);
    chk({tag, "_raddr"}, 32'(bif.raddr_o),   32'd0);
    chk({tag, "_sel"},   32'(bif.sel_o),     32'd0);
    chk({tag, "_data"},  bif.data_o,         32'd0);
    chk({tag, "_busy"},  32'(busy_o),        32'd0);
    chk({tag, "_err"},   32'(err_o),         32'd0);
  endtask

  initial begin
    int we0, rd0, er0, t0, cyc;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Write 0x12345678 to 0x10, all lanes.
    we0 = we_n; rd0 = rd_n; er0 = err_n; t0 = tx_n;
    send_write(8'h10, 8'h0F, 32'h12345678);
    wait_tx("wr_txn", t0 + 1);
    chk("wr_we",   we_n - we0, 1);
    chk("wr_addr", 32'(w_addr), 32'h10);
    chk("wr_sel",  32'(w_sel),  32'hF);
    chk("wr_data", w_data,      32'h12345678);
    chk("wr_ack",  32'(tx_log[t0]), 32'h06);
    chk("wr_err",  err_n - er0, 0);
    repeat (20) @(negedge clk);
    chk("wr_idle", 32'(busy_o), 32'd0);

    // Read 0x08 -> CAFEF00D, LSB first.
    we0 = we_n; rd0 = rd_n; t0 = tx_n;
    send_byte(8'h52, 1'b1); send_byte(8'h08, 1'b1);
    wait_tx("rd_txn", t0 + 4);
    chk("rd_rd",   rd_n - rd0, 1);
    chk("rd_addr", 32'(r_addr), 32'h08);
    chk("rd_b0",   32'(tx_log[t0]),   32'h0D);
    chk("rd_b1",   32'(tx_log[t0+1]), 32'hF0);
    chk("rd_b2",   32'(tx_log[t0+2]), 32'hFE);
    chk("rd_b3",   32'(tx_log[t0+3]), 32'hCA);
    chk("rd_we",   we_n - we0, 0);
    repeat (20) @(negedge clk);

    // Bad command -> NAK + err, then a good write with partial lanes.
    we0 = we_n; rd0 = rd_n; er0 = err_n; t0 = tx_n;
    send_byte(8'h41, 1'b1);
    wait_tx("bad_txn", t0 + 1);
    chk("bad_nak", 32'(tx_log[t0]), 32'h15);
    chk("bad_err", err_n - er0, 1);
    chk("bad_we",  we_n - we0, 0);
    chk("bad_rd",  rd_n - rd0, 0);
    repeat (20) @(negedge clk);
    t0 = tx_n;
    send_write(8'h24, 8'hF5, 32'h44332211);
    wait_tx("bad2_txn", t0 + 1);
    chk("bad2_we",   we_n - we0, 1);
    chk("bad2_addr", 32'(w_addr), 32'h24);
    chk("bad2_sel",  32'(w_sel),  32'h5);
    chk("bad2_data", w_data,      32'h44332211);
    chk("bad2_ack",  32'(tx_log[t0]), 32'h06);
    repeat (20) @(negedge clk);

    // Framing error inside a write frame: abort, no reply.
    we0 = we_n; er0 = err_n; t0 = tx_n;
    send_byte(8'h57, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h0F, 1'b1);
    send_byte(8'h78, 1'b0);
    repeat (400) @(negedge clk);
    chk("fe_err", err_n - er0, 1);
    chk("fe_we",  we_n - we0, 0);
    chk("fe_tx",  tx_n - t0, 0);
    chk("fe_busy", 32'(busy_o), 32'd0);
    send_write(8'h30, 8'h0C, 32'hDDCCBBAA);
    wait_tx("fe2_txn", t0 + 1);
    chk("fe2_we",   we_n - we0, 1);
    chk("fe2_addr", 32'(w_addr), 32'h30);
    chk("fe2_sel",  32'(w_sel),  32'hC);
    chk("fe2_data", w_data,      32'hDDCCBBAA);
    chk("fe2_ack",  32'(tx_log[t0]), 32'h06);
    repeat (20) @(negedge clk);

    // Timeout: 'W' + addr then silence. rx_valid of the addr byte lands
    // about 8 clocks before send_byte returns; err follows ~500 clocks later.
    we0 = we_n; er0 = err_n; t0 = tx_n;
    send_byte(8'h57, 1'b1); send_byte(8'h10, 1'b1);
    cyc = 0;
    while (err_n == er0 && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("to_seen",   err_n - er0, 1);
    chk("to_window", 32'(cyc >= 470 && cyc <= 520), 32'd1);
    repeat (5) @(negedge clk);
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_tx",   tx_n - t0, 0);
    chk("to_txpin", 32'(tx_pin), 32'd1);
    chk("to_we",   we_n - we0, 0);
    chk("to_once", err_n - er0, 1);

    // Reset during the second read reply byte, then a clean read.
    t0 = tx_n; rd0 = rd_n;
    send_byte(8'h52, 1'b1); send_byte(8'h08, 1'b1);
    wait_tx("rr_first", t0 + 1);
    repeat (60) @(negedge clk);
    chk("rr_mid_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rr");
    rst = 1'b0;
    repeat (250) @(negedge clk);
    t0 = tx_n; rd0 = rd_n;
    send_byte(8'h52, 1'b1); send_byte(8'h0C, 1'b1);
    wait_tx("rr2_txn", t0 + 4);
    chk("rr2_rd",   rd_n - rd0, 1);
    chk("rr2_addr", 32'(r_addr), 32'h0C);
    chk("rr2_b0",   32'(tx_log[t0]),   32'h0D);
    chk("rr2_b1",   32'(tx_log[t0+1]), 32'hF0);
    chk("rr2_b2",   32'(tx_log[t0+2]), 32'hFE);
    chk("rr2_b3",   32'(tx_log[t0+3]), 32'hCA);

    repeat (20) @(negedge clk);
    chk("err_width", err_long, 0);
    chk("tx_stop",   stop_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
